// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between N_REQ senders. Each sender offers a
//   5-bit payload; the winner of a round-robin search gets its payload tagged
//   with its index ({idx[2:0], payload[4:0]}), the byte is launched with a
//   one-cycle TxD_start, and the arbiter then follows TxD_busy until the
//   transmitter is idle again. If busy never rises within BUSY_TIMEOUT clocks
//   of the launch, the byte is dropped and a sticky timeout_err is raised.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   req[N_REQ]     per-requester request level (sampled only while idle)
//   payload        requester i payload at [5i+4:5i]
//   grant[N_REQ]   one-cycle acknowledge, payload of that requester captured
//   TxD_start      one-cycle launch pulse to the transmitter
//   TxD_data       byte being transmitted, held until the next grant
//   TxD_busy       transmitter busy
//   active         high whenever the arbiter is not idle
//   timeout_err    sticky: busy never seen after a launch
//   clear_err      synchronous clear of timeout_err (a new timeout wins)
module uart_tx_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [5*N_REQ-1:0] payload,
  output logic [N_REQ-1:0]   grant,
  output logic               TxD_start,
  output logic [7:0]         TxD_data,
  input  logic               TxD_busy,
  output logic               active,
  output logic               timeout_err,
  input  logic               clear_err
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t           state;
  logic [2:0]       rr_ptr;
  logic [7:0]       tmo_cnt;

  logic [7:0]       req_ext;
  logic [3:0]       cand;
  logic             win_found;
  logic [2:0]       win_idx;
  logic [4:0]       win_pay;
  logic [N_REQ-1:0] grant_nxt;
  logic [2:0]       rr_next;

  // Widened copy so the 3-bit candidate index is always in range.
  assign req_ext = 8'(req);

  // Round-robin search: first requester at or after rr_ptr, wrapping at N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = 4'({1'b0, rr_ptr} + k);
      if (cand >= 4'(N_REQ)) begin
        cand = cand - 4'(N_REQ);
      end
      if (!win_found && req_ext[cand[2:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[2:0];
      end
    end
  end

  // Winner's payload and one-hot grant; other payloads are never looked at.
  always_comb begin
    win_pay   = '0;
    grant_nxt = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_idx == 3'(i)) begin
        win_pay      = payload[5*i +: 5];
        grant_nxt[i] = win_found;
      end
    end
  end

  assign rr_next = (win_idx == 3'(N_REQ - 1)) ? '0 : win_idx + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      tmo_cnt     <= '0;
      grant       <= '0;
      TxD_start   <= 1'b0;
      TxD_data    <= '0;
      active      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      grant     <= '0;
      TxD_start <= 1'b0;
      // Cleared first so a timeout in the same cycle below takes precedence.
      if (clear_err) begin
        timeout_err <= 1'b0;
      end
      case (state)
        IDLE: begin
          // A busy transmitter still belongs to a previous byte: hold off.
          if (win_found && !TxD_busy) begin
            grant    <= grant_nxt;
            TxD_data <= {win_idx, win_pay};
            rr_ptr   <= rr_next;
            state    <= START;
            active   <= 1'b1;
          end
        end
        START: begin
          TxD_start <= 1'b1;
          tmo_cnt   <= '0;
          state     <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (TxD_busy) begin
            state <= WAIT_DONE;
          end else if (tmo_cnt == 8'(BUSY_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
            active      <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        WAIT_DONE: begin
          if (!TxD_busy) begin
            state  <= IDLE;
            active <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter (TxD_start/TxD_data/TxD_busy) between up to 8 independent senders: sensor scan left/right halves, move-done reports, status messages.
- Each sender offers a 5-bit payload. The arbiter tags it with the requester index, forms one byte, launches it, and tracks the transmitter until it is idle again.
- Round-robin fairness; guards against a transmitter that never asserts busy.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- BUSY_TIMEOUT, 16, clocks allowed between TxD_start and TxD_busy rising; legal range 2..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- req  in  N_REQ  per-requester request level
- payload  in  5*N_REQ  requester i's payload at bits [5i+4:5i]
- grant  out  N_REQ  one-cycle acknowledge; payload i captured
- TxD_start  out  1  one-cycle launch pulse to UART transmitter
- TxD_data  out  8  byte to transmit
- TxD_busy  in  1  UART transmitter busy
- active  out  1  high whenever state is not IDLE
- timeout_err  out  1  sticky: busy never seen after a launch
- clear_err  in  1  synchronous clear of timeout_err

Behaviour:
- Reset (rst_n low, async): state=IDLE; grant=0, TxD_start=0, TxD_data=8'h00, active=0, timeout_err=0; rr pointer=0; timeout counter=0.
- Byte format: TxD_data = {idx[2:0], payload_idx[4:0]}, where idx is the granted requester number.
- Request handshake:
  - Requester raises req[i] with payload stable.
  - Holds both until it sees grant[i] for one cycle.
  - Must drop req[i] in the cycle after grant; req still high then counts as a new request.
- Arbitration:
  - Round-robin, starting the search at rr pointer, ascending, wrapping at N_REQ-1 to 0.
  - After granting i, rr pointer = (i+1) mod N_REQ.
  - Exactly one grant bit high at a time.
- State IDLE:
  - Condition: some req high AND TxD_busy low.
  - Action: latch winner's byte into TxD_data, pulse grant[winner], go to START.
  - If TxD_busy high (transmitter owned by a prior byte), stay in IDLE and issue no grant.
- State START: TxD_start=1 for exactly this cycle; clear timeout counter; go to WAIT_BUSY.
- State WAIT_BUSY:
  - TxD_busy=1: go to WAIT_DONE.
  - Otherwise increment counter. When counter == BUSY_TIMEOUT-1 with busy still low: set timeout_err, go to IDLE. The byte is dropped, not retried.
- State WAIT_DONE: TxD_busy=0 -> IDLE. No timeout here.
- Latency:
  - grant appears in the first clock edge with req high in IDLE and busy low.
  - TxD_start follows 1 cycle later.
  - Minimum 4 cycles between grants when busy lasts 1 cycle.
- TxD_data holds its value until the next grant. It is not cleared on return to IDLE.
- Requests arriving in a non-IDLE state wait; the request level is sampled only in IDLE.
- Timeout and error clear:
  - clear_err clears timeout_err.
  - If clear_err and a timeout occur in the same cycle, set wins.
- Reset mid-operation: everything returns to reset values immediately. A requester whose grant was already issued has lost its byte; the system layer re-issues it. TxD_start is never left high.
- Payload bits of requesters not granted are ignored. Unused index values (>= N_REQ) never appear in the tag.

Test Plan:
- Single sender: N_REQ=4, req=4'b0010, payload1=5'b10110; UART model raises busy 2 cycles after start for 10 cycles.
  - grant=4'b0010 for one cycle, then TxD_start for one cycle.
  - TxD_data=8'h36 throughout; active falls the cycle after busy drops.
- Contention round-robin: req=4'b1011 held, each requester dropping after its grant and re-raising once.
  - Grant order is 0,1,3,0,1,3 with rr pointer starting at 0.
  - No two grants closer than one full transmit.
- Timeout: BUSY_TIMEOUT=16, busy never asserted after start.
  - timeout_err rises exactly 16 cycles after TxD_start, state returns to IDLE, next pending req is granted.
  - clear_err pulse clears timeout_err; simultaneous clear and new timeout leaves timeout_err=1.
- Busy at idle: TxD_busy held high externally while req[2]=1 for 20 cycles.
  - No grant and no TxD_start during that time.
  - Grant occurs on the first edge after busy falls.
- Reset mid-transfer: assert rst_n low during WAIT_DONE, between clock edges.
  - All outputs are reset values before the next edge; rr pointer=0.
  - After release, a pending req[0] is granted normally.
- Back-to-back same sender: req[3] with payload 5'h1F, re-raised immediately after each of 3 grants.
  - Three bytes of 8'h7F, each started only after the previous busy falls.
